// File: rtl/dco_ctrl_pkg.sv
// Shared types, default widths and helpers for the DCO frequency-tracking loop.
package dco_ctrl_pkg;

  // Measurement FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2,
    UPDATE  = 2'd3
  } state_e;

  localparam int DEF_BIT_COUNT  = 24;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int DEF_GAIN_SHIFT = 4;
  localparam int DEF_LOCK_COUNT = 8;

  // Wide signed working width for clamping; must cover BIT_COUNT+2.
  localparam int CALC_W = 64;

  // Saturate a signed value into [lo, hi].
  function automatic logic signed [CALC_W-1:0] clamp(
    input logic signed [CALC_W-1:0] val,
    input logic signed [CALC_W-1:0] lo,
    input logic signed [CALC_W-1:0] hi
  );
    if (val < lo) return lo;
    if (val > hi) return hi;
    return val;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// Rise on din to pulse output is three clk cycles.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic meta;
  logic sync;
  logic prev;

  // Synchronize din, remember the previous synchronized level, emit one-cycle pulse on 0->1.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      meta  <= din;
      sync  <= meta;
      prev  <= sync;
      pulse <= sync & ~prev;
    end
  end

endmodule

// File: rtl/dco_period_tracker.sv
// Measures the period of signal_in in clk cycles and steps the DCO control word
// toward a programmed target with a saturating proportional update.
module dco_period_tracker
  import dco_ctrl_pkg::*;
#(
  parameter int                   BIT_COUNT  = DEF_BIT_COUNT,
  parameter int                   CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int                   GAIN_SHIFT = DEF_GAIN_SHIFT,
  parameter logic [BIT_COUNT-1:0] CTRL_INIT  = BIT_COUNT'(1),
  parameter logic [BIT_COUNT-1:0] CTRL_MIN   = BIT_COUNT'(1),
  parameter logic [BIT_COUNT-1:0] CTRL_MAX   = '1,
  parameter int                   LOCK_COUNT = DEF_LOCK_COUNT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 signal_in,
  input  logic [CNT_WIDTH-1:0] target_period,
  input  logic [CNT_WIDTH-1:0] lock_tol,
  output logic [BIT_COUNT-1:0] ctrl_word,
  output logic                 ctrl_valid,
  output logic [CNT_WIDTH-1:0] meas_period,
  output logic                 locked,
  output logic                 no_signal
);

  localparam int ERR_W = CNT_WIDTH + 1;
  localparam int SUM_W = BIT_COUNT + 2;
  localparam int LCK_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [LCK_W-1:0]     LOCK_MAX = LCK_W'(LOCK_COUNT);
  localparam logic [LCK_W-1:0]     LOCK_PRE = LCK_W'(LOCK_COUNT - 1);

  state_e                 state;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [LCK_W-1:0]       lock_cnt;
  logic                   sig_edge;

  logic signed [ERR_W-1:0] err;
  logic signed [ERR_W-1:0] shifted;
  logic signed [ERR_W-1:0] step;
  logic        [ERR_W-1:0] abs_err;
  logic signed [SUM_W-1:0] sum;
  logic                    in_tol;
  logic [BIT_COUNT-1:0]    ctrl_next;

  edge_sync u_edge_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (signal_in),
    .pulse (sig_edge)
  );

  // Error, proportional step with a minimum magnitude of one, and clamped next control word.
  always_comb begin
    // NOTE: every output of this block is assigned on every path, so no latch is inferred.
    err     = $signed({1'b0, meas_period}) - $signed({1'b0, target_period});
    shifted = err >>> GAIN_SHIFT;
    step    = shifted;
    if (shifted == '0 && err != '0) begin
      step = err[ERR_W-1] ? '1 : ERR_W'(1);
    end
    abs_err   = err[ERR_W-1] ? ERR_W'(-err) : ERR_W'(err);
    in_tol    = (abs_err <= {1'b0, lock_tol});
    sum       = $signed({2'b00, ctrl_word}) + SUM_W'(step);
    ctrl_next = BIT_COUNT'(clamp(CALC_W'(sum),
                                 $signed(CALC_W'(CTRL_MIN)),
                                 $signed(CALC_W'(CTRL_MAX))));
  end

  // Measurement FSM, period counter, control-word update, lock and timeout tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ctrl_word   <= CTRL_INIT;
      ctrl_valid  <= 1'b0;
      meas_period <= '0;
      locked      <= 1'b0;
      lock_cnt    <= '0;
      no_signal   <= 1'b0;
    end else begin
      ctrl_valid <= 1'b0;
      if (!en) begin
        // Disabled: drop lock, keep the control word and last measurement.
        state    <= IDLE;
        cnt      <= '0;
        locked   <= 1'b0;
        lock_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            state <= ARMED;
          end
          ARMED: begin
            // First edge only starts timing.
            if (sig_edge) begin
              cnt   <= CNT_WIDTH'(1);
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (sig_edge) begin
              meas_period <= cnt;
              cnt         <= CNT_WIDTH'(1);
              state       <= UPDATE;
            end else if (cnt == CNT_MAX) begin
              // No edge within counter range: flag it and wait for a fresh arming edge.
              no_signal <= 1'b1;
              locked    <= 1'b0;
              lock_cnt  <= '0;
              cnt       <= '0;
              state     <= ARMED;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          UPDATE: begin
            // Counter keeps running so the next period is timed from the last edge.
            cnt        <= cnt + 1'b1;
            ctrl_word  <= ctrl_next;
            ctrl_valid <= 1'b1;
            no_signal  <= 1'b0;
            if (in_tol) begin
              if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + 1'b1;
              locked <= (lock_cnt >= LOCK_PRE);
            end else begin
              lock_cnt <= '0;
              locked   <= 1'b0;
            end
            state <= MEASURE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dco_period_tracker.sv
// Scoreboard bench for dco_period_tracker: stimulus pushes hand-computed
// expected updates, a negedge monitor pops one per ctrl_valid pulse.
module tb_dco_period_tracker;

  localparam int BW = 12;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b1;
  logic          stim_sig = 1'b0;
  logic          dco_out  = 1'b0;
  logic          closed_loop = 1'b0;
  logic          signal_in;
  logic [CW-1:0] target_period = 8'd40;
  logic [CW-1:0] lock_tol      = 8'd1;
  logic [BW-1:0] ctrl_word;
  logic          ctrl_valid;
  logic [CW-1:0] meas_period;
  logic          locked;
  logic          no_signal;

  assign signal_in = closed_loop ? dco_out : stim_sig;

  dco_period_tracker #(
    .BIT_COUNT  (BW),
    .CNT_WIDTH  (CW),
    .GAIN_SHIFT (4),
    .CTRL_INIT  (12'd40),
    .CTRL_MIN   (12'd1),
    .CTRL_MAX   (12'd52),
    .LOCK_COUNT (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .signal_in     (signal_in),
    .target_period (target_period),
    .lock_tol      (lock_tol),
    .ctrl_word     (ctrl_word),
    .ctrl_valid    (ctrl_valid),
    .meas_period   (meas_period),
    .locked        (locked),
    .no_signal     (no_signal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [BW-1:0] ctrl;
    logic          lck;
    logic [CW-1:0] meas;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic expect_upd(input int c, input int l, input int m);
    exp_t e;
    e.ctrl = BW'(c);
    e.lck  = (l != 0);
    e.meas = CW'(m);
    exp_q.push_back(e);
  endtask

  // One period of stim_sig starting at a rise: high half, low half, next rise.
  task automatic run_interval(input int per, input int tgt, input int c, input int l, input int m);
    repeat (per / 2) @(negedge clk);
    stim_sig      = 1'b0;
    target_period = CW'(tgt);
    expect_upd(c, l, m);
    repeat (per - per / 2) @(negedge clk);
    stim_sig = 1'b1;
  endtask

  task automatic arm_rise();
    @(negedge clk);
    stim_sig = 1'b0;
    repeat (4) @(negedge clk);
    stim_sig = 1'b1;
  endtask

  // Simple accumulator DCO: toggles its output each time the phase wraps past 1000.
  int dco_acc = 0;
  always @(posedge clk) begin
    if (!closed_loop) begin
      dco_acc <= 0;
      dco_out <= 1'b0;
    end else if (dco_acc + int'(ctrl_word) >= 1000) begin
      dco_acc <= dco_acc + int'(ctrl_word) - 1000;
      dco_out <= ~dco_out;
    end else begin
      dco_acc <= dco_acc + int'(ctrl_word);
    end
  end

  int cl_updates = 0;
  int cl_lock_at = 0;
  int cl_hist[$];

  // Monitor: every ctrl_valid pulse consumes one expected update.
  always @(negedge clk) begin
    if (!rst && ctrl_valid === 1'b1) begin
      if (closed_loop) begin
        cl_updates++;
        cl_hist.push_back(int'(meas_period));
        if (locked && cl_lock_at == 0) cl_lock_at = cl_updates;
      end else if (exp_q.size() == 0) begin
        check("spurious_ctrl_valid", 32'(ctrl_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("upd_ctrl_word", 32'(ctrl_word), 32'(mon_e.ctrl));
        check("upd_locked", 32'(locked), 32'(mon_e.lck));
        check("upd_meas_period", 32'(meas_period), 32'(mon_e.meas));
        check("upd_no_signal", 32'(no_signal), 32'd0);
      end
    end
  end

  initial begin
    int sum16;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_ctrl_word", 32'(ctrl_word), 32'd40);
    check("rst_ctrl_valid", 32'(ctrl_valid), 32'd0);
    check("rst_meas_period", 32'(meas_period), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_no_signal", 32'(no_signal), 32'd0);
    rst = 1'b0;

    // On target: control word holds, lock after 8 in-tolerance updates.
    arm_rise();
    for (int k = 1; k <= 9; k++) run_interval(40, 40, 40, (k >= 8) ? 1 : 0, 40);

    // Enable drop clears lock, holds control word and measurement.
    repeat (8) @(negedge clk);
    en       = 1'b0;
    stim_sig = 1'b0;
    @(negedge clk);
    check("en_drop_locked", 32'(locked), 32'd0);
    check("en_drop_ctrl_held", 32'(ctrl_word), 32'd40);
    check("en_drop_meas_held", 32'(meas_period), 32'd40);
    repeat (4) @(negedge clk);
    en = 1'b1;
    arm_rise();

    // Slow input: err 60 -> step 3.
    run_interval(100, 40, 43, 0, 100);
    // Small error: step forced to +1; walk up to CTRL_MAX-1, locking on the way.
    run_interval(41, 40, 44, 0, 41);
    for (int k = 1; k <= 7; k++) run_interval(41, 40, 44 + k, (k == 7) ? 1 : 0, 41);
    // err +200 from CTRL_MAX-1 clamps to CTRL_MAX, and stays there.
    run_interval(240, 40, 52, 0, 240);
    run_interval(240, 40, 52, 0, 240);
    // Large negative error: step -15 down to the lower clamp.
    run_interval(10, 250, 37, 0, 10);
    run_interval(10, 250, 22, 0, 10);
    run_interval(10, 250, 7, 0, 10);
    run_interval(10, 250, 1, 0, 10);
    run_interval(10, 250, 1, 0, 10);
    // Period 30 at CTRL_MIN stays at CTRL_MIN.
    run_interval(30, 40, 1, 0, 30);
    // Re-lock at CTRL_MIN before the timeout test.
    for (int k = 1; k <= 8; k++) run_interval(40, 40, 1, (k == 8) ? 1 : 0, 40);

    // Timeout: counter reaches 255 exactly 259 cycles after the last rise.
    for (int i = 1; i <= 258; i++) begin
      @(negedge clk);
      if (i == 20) stim_sig = 1'b0;
    end
    check("no_signal_not_early", 32'(no_signal), 32'd0);
    @(negedge clk);
    check("no_signal_set", 32'(no_signal), 32'd1);
    check("timeout_locked", 32'(locked), 32'd0);
    check("timeout_ctrl_held", 32'(ctrl_word), 32'd1);
    check("timeout_meas_held", 32'(meas_period), 32'd40);

    // Recovery: arming edge then one measurement clears no_signal.
    arm_rise();
    check("no_signal_held_after_arm", 32'(no_signal), 32'd1);
    run_interval(40, 40, 1, 0, 40);
    repeat (6) @(negedge clk);
    check("no_signal_cleared", 32'(no_signal), 32'd0);

    // Reset midway through a period (during the low phase).
    repeat (14) @(negedge clk);
    stim_sig = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ctrl_word", 32'(ctrl_word), 32'd40);
    check("midrst_ctrl_valid", 32'(ctrl_valid), 32'd0);
    check("midrst_meas_period", 32'(meas_period), 32'd0);
    check("midrst_locked", 32'(locked), 32'd0);
    check("midrst_no_signal", 32'(no_signal), 32'd0);
    rst = 1'b0;
    repeat (9) @(negedge clk);
    stim_sig = 1'b1;
    run_interval(40, 40, 40, 0, 40);
    repeat (10) @(negedge clk);
    check("all_updates_seen", 32'(exp_q.size()), 32'd0);

    // Closed loop with the accumulator DCO, target 64.
    en = 1'b0;
    repeat (3) @(negedge clk);
    closed_loop   = 1'b1;
    target_period = 8'd64;
    lock_tol      = 8'd2;
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (cl_lock_at != 0 && cl_updates >= cl_lock_at + 16) break;
    end
    check("cl_lock_within_200", 32'((cl_lock_at != 0 && cl_lock_at <= 200) ? 1 : 0), 32'd1);
    check("cl_locked_final", 32'(locked), 32'd1);
    sum16 = 0;
    if (cl_hist.size() >= 16) begin
      for (int i = cl_hist.size() - 16; i < cl_hist.size(); i++) sum16 += cl_hist[i];
    end
    check("cl_avg_period_within_1",
          32'((sum16 >= 1008 && sum16 <= 1040) ? 1 : 0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
